// File: rtl/spi_ram_bridge_p_if.sv
// SPI pin bundle for spi_ram_bridge_p, plus read-only debug taps (FSM state and
// read-address-seen flag) so checkers can observe the controller directly.
interface spi_ram_bridge_p_if;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic       busy;
  logic       frame_err;
  logic [2:0] state_dbg;
  logic       rd_addr_seen_dbg;

  // SS_n/MOSI come from the SPI master; everything else is produced by the bridge.
  modport slave (
    input  SS_n,
    input  MOSI,
    output MISO,
    output busy,
    output frame_err,
    output state_dbg,
    output rd_addr_seen_dbg
  );

  modport master (
    output SS_n,
    output MOSI,
    input  MISO,
    input  busy,
    input  frame_err,
    input  state_dbg,
    input  rd_addr_seen_dbg
  );
endinterface

// File: rtl/spi_ram_bridge_p.sv
// SPI slave + single-port RAM bridge. Frame = op[1:0] then W payload bits, MSB first.
// Optional macro SPI_RAM_AUTO_INC_EN enables pointer auto-increment (burst) mode.
module spi_ram_bridge_p #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8   // must not exceed DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_ram_bridge_p_if.slave  spi
);

  localparam int W         = DATA_WIDTH;
  localparam int A         = ADDR_WIDTH;
  localparam int MEM_DEPTH = 2 ** A;
  localparam int CW        = $clog2(W + 3);

  localparam logic [CW-1:0] CNT_LAST = CW'(W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(W + 2);
  localparam logic [CW-1:0] CNT_TX   = CW'(W);

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RDATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    MISO_OUT  = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [W:0]      shreg;
  logic            miso_q;
  logic            busy_q;
  logic            frame_err_q;

  logic            rx_valid;
  logic [W+1:0]    rx_data;
  logic [1:0]      rx_op;
  logic [W-1:0]    rx_payload;
  logic            tx_valid;

  logic [A-1:0]    wr_addr;
  logic [A-1:0]    rd_addr;
  logic            rd_addr_seen;
  logic [W-1:0]    dout;
  logic [W-1:0]    mem [MEM_DEPTH];

  logic [W+1:0]    frame_in;

  // The incoming bit appended to what has been shifted so far.
  assign frame_in   = {shreg, spi.MOSI};
  assign rx_op      = rx_data[W+1:W];
  assign rx_payload = rx_data[W-1:0];

  assign spi.MISO             = miso_q;
  assign spi.busy             = busy_q;
  assign spi.frame_err        = frame_err_q;
  assign spi.state_dbg        = state;
  assign spi.rd_addr_seen_dbg = rd_addr_seen;

  // ---------------------------------------------------------------------------
  // Controller FSM. bit_cnt counts received bits in the shift states, and
  // transmitted bits in MISO_OUT. Once a frame is complete the FSM parks
  // (bit_cnt == CNT_FULL) and ignores MOSI until SS_n rises.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
    end else begin
      frame_err_q <= 1'b0;
      rx_valid    <= 1'b0;

      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          if (!spi.SS_n) begin
            state   <= CHK_CMD;
            busy_q  <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end

        CHK_CMD: begin
          if (spi.SS_n) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end else begin
            shreg   <= frame_in[W:0];
            bit_cnt <= CW'(1);
            if (!spi.MOSI)
              state <= WRITE;
            else if (rd_addr_seen)
              state <= READ_DATA;
            else
              state <= READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt == CNT_LAST) begin
            // Last bit: the frame completes even if SS_n rises on this same edge.
            shreg   <= frame_in[W:0];
            bit_cnt <= CNT_FULL;
            if (state == READ_ADD && frame_in[W+1:W] == OP_RDATA) begin
              frame_err_q <= 1'b1;
            end else begin
              rx_valid <= 1'b1;
              rx_data  <= frame_in;
            end
            if (spi.SS_n) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              miso_q <= 1'b0;
            end
          end else if (bit_cnt == CNT_FULL) begin
            if (spi.SS_n) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              miso_q <= 1'b0;
            end else if (state == READ_DATA && rx_valid && rx_op == OP_RDATA) begin
              state   <= MISO_OUT;
              bit_cnt <= '0;
            end
          end else if (spi.SS_n) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end else begin
            shreg   <= frame_in[W:0];
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        MISO_OUT: begin
          if (spi.SS_n) begin
            // Fewer than W bits presented means the read was cut short.
            if (bit_cnt < CNT_TX)
              frame_err_q <= 1'b1;
            state  <= IDLE;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
          end else if (tx_valid) begin
            miso_q  <= dout[W-1];
            shreg   <= {dout, 1'b0};
            bit_cnt <= CW'(1);
          end else if (bit_cnt != '0 && bit_cnt < CNT_TX) begin
            miso_q  <= shreg[W-1];
            shreg   <= {shreg[W-1:0], 1'b0};
            bit_cnt <= bit_cnt + CW'(1);
          end else begin
            miso_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          miso_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Opcode actions, one cycle after the last bit is captured.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr      <= '0;
      rd_addr      <= '0;
      rd_addr_seen <= 1'b0;
      tx_valid     <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (rx_op)
          OP_WADDR: wr_addr <= rx_payload[A-1:0];
          OP_WDATA: begin
`ifdef SPI_RAM_AUTO_INC_EN
            wr_addr <= wr_addr + 1'b1;
`endif
          end
          OP_RADDR: begin
            rd_addr      <= rx_payload[A-1:0];
            rd_addr_seen <= 1'b1;
          end
          default: begin
            tx_valid <= 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
            // Keep the read pointer armed so back-to-back read frames stream.
            rd_addr      <= rd_addr + 1'b1;
            rd_addr_seen <= 1'b1;
`else
            rd_addr_seen <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

  // RAM array: deliberately not reset.
  always_ff @(posedge clk) begin
    if (rx_valid && rx_op == OP_WDATA)
      mem[wr_addr] <= rx_payload;
    if (rx_valid && rx_op == OP_RDATA)
      dout <= mem[rd_addr];
  end

endmodule

// File: tb/tb_spi_ram_bridge_p.sv
// Directed self-checking bench for spi_ram_bridge_p (W=8, A=8); the expected
// values follow SPI_RAM_AUTO_INC_EN when that macro is defined.
module tb_spi_ram_bridge_p;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READ_ADD  = 3'd3;
  localparam logic [2:0] ST_READ_DATA = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_ram_bridge_p_if bus ();

  spi_ram_bridge_p #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         n_checks   = 0;
  int         n_fail     = 0;
  int         err_pulses = 0;
  int         miso_ones  = 0;
  int         busy_low   = 0;
  logic [2:0] st_cmd;
  int         e0;
  int         m0;
  logic [7:0] rd_val;
  logic       seen_exp;

  // Monitors sample on the rising edge, i.e. the value held over the previous cycle.
  always @(posedge clk) begin
    if (bus.frame_err === 1'b1) err_pulses++;
    if (bus.MISO === 1'b1) miso_ones++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Sends the first nbits of {op, pl}. early_ss raises SS_n together with the last bit.
  task automatic send_frame(input logic [1:0] op, input logic [7:0] pl,
                            input int nbits, input bit early_ss);
    logic [9:0] f;
    f = {op, pl};
    @(negedge clk);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    @(negedge clk);
    if (bus.busy !== 1'b1) busy_low++;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = f[9-i];
      if (early_ss && i == nbits - 1) bus.SS_n = 1'b1;
      @(negedge clk);
      if (i == 0) st_cmd = bus.state_dbg;
      if (!(early_ss && i == nbits - 1) && bus.busy !== 1'b1) busy_low++;
    end
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_frame(input logic [1:0] op, input logic [7:0] pl);
    send_frame(op, pl, 10, 1'b0);
    end_frame();
  endtask

  // Read-data frame; collects nbits of MISO. A full read is scored against exp_q.
  task automatic read_frame(input int nbits, output logic [7:0] v);
    logic [7:0] exp;
    v = '0;
    send_frame(2'b11, 8'h00, 10, 1'b0);
    @(negedge clk);
    check_eq("read_latency_pre", {31'd0, bus.MISO}, 32'd0);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      v = {v[6:0], bus.MISO};
    end
    if (nbits == 8) begin
      @(negedge clk);
      check_eq("miso_return_zero", {31'd0, bus.MISO}, 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("exp_q_underflow", 32'd1, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check_eq("read_data", {24'd0, v}, {24'd0, exp});
      end
      end_frame();
    end
  endtask

  task automatic do_reset();
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check_eq("reset_miso", {31'd0, bus.MISO}, 32'd0);
    check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check_eq("reset_state", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});
    check_eq("reset_seen", {31'd0, bus.rd_addr_seen_dbg}, 32'd0);

    // First data write after reset lands at address 0.
    write_frame(2'b01, 8'h77);
    write_frame(2'b10, 8'h00);
    exp_q.push_back(8'h77);
    read_frame(8, rd_val);
`ifdef SPI_RAM_AUTO_INC_EN
    seen_exp = 1'b1;
`else
    seen_exp = 1'b0;
`endif
    check_eq("seen_after_read", {31'd0, bus.rd_addr_seen_dbg}, {31'd0, seen_exp});

    // Basic write / read-back.
    write_frame(2'b00, 8'h3C);
    write_frame(2'b01, 8'hA5);
    write_frame(2'b10, 8'h3C);
    exp_q.push_back(8'hA5);
    read_frame(8, rd_val);

    // Abort after 5 bits of a write to 0x10.
    write_frame(2'b00, 8'h10);
    write_frame(2'b01, 8'hC3);
    write_frame(2'b00, 8'h10);
    e0 = err_pulses;
    send_frame(2'b01, 8'h5A, 5, 1'b0);
    end_frame();
    check_eq("abort_err_pulse", err_pulses - e0, 32'd1);
    check_eq("abort_state", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    write_frame(2'b10, 8'h10);
    exp_q.push_back(8'hC3);
    read_frame(8, rd_val);

    // Address reload while in READ_DATA: no MISO phase, no error.
    write_frame(2'b10, 8'h3C);
    e0 = err_pulses;
    m0 = miso_ones;
    write_frame(2'b10, 8'h10);
    check_eq("reload_route", {29'd0, st_cmd}, {29'd0, ST_READ_DATA});
    check_eq("reload_no_err", err_pulses - e0, 32'd0);
    check_eq("reload_no_miso", miso_ones - m0, 32'd0);
    exp_q.push_back(8'hC3);
    read_frame(8, rd_val);

    // SS_n rises on the same edge as the last captured bit.
    write_frame(2'b00, 8'h20);
    e0 = err_pulses;
    send_frame(2'b01, 8'hE7, 10, 1'b1);
    end_frame();
    check_eq("late_ss_no_err", err_pulses - e0, 32'd0);
    write_frame(2'b10, 8'h20);
    exp_q.push_back(8'hE7);
    read_frame(8, rd_val);

    // Pointer behaviour across 0xFF.
    write_frame(2'b00, 8'hFF);
    write_frame(2'b01, 8'h11);
    write_frame(2'b01, 8'h22);
    write_frame(2'b10, 8'hFF);
`ifdef SPI_RAM_AUTO_INC_EN
    e0 = err_pulses;
    exp_q.push_back(8'h11);
    read_frame(8, rd_val);
    exp_q.push_back(8'h22);
    read_frame(8, rd_val);
    check_eq("burst_no_err", err_pulses - e0, 32'd0);
`else
    exp_q.push_back(8'h22);
    read_frame(8, rd_val);
    e0 = err_pulses;
    m0 = miso_ones;
    send_frame(2'b11, 8'h00, 10, 1'b0);
    check_eq("second_read_route", {29'd0, st_cmd}, {29'd0, ST_READ_ADD});
    repeat (12) @(negedge clk);
    end_frame();
    check_eq("second_read_err", err_pulses - e0, 32'd1);
    check_eq("second_read_no_miso", miso_ones - m0, 32'd0);
    write_frame(2'b10, 8'h00);
    exp_q.push_back(8'h77);
    read_frame(8, rd_val);
`endif

    // Illegal read directly after reset.
    do_reset();
    e0 = err_pulses;
    m0 = miso_ones;
    send_frame(2'b11, 8'h00, 10, 1'b0);
    check_eq("illegal_route", {29'd0, st_cmd}, {29'd0, ST_READ_ADD});
    repeat (12) @(negedge clk);
    end_frame();
    check_eq("illegal_err_pulse", err_pulses - e0, 32'd1);
    check_eq("illegal_no_miso", miso_ones - m0, 32'd0);
    check_eq("illegal_seen", {31'd0, bus.rd_addr_seen_dbg}, 32'd0);

    // SS_n raised in MISO_OUT after 4 of 8 bits. mem[0x3C] still holds 0xA5.
    write_frame(2'b10, 8'h3C);
    e0 = err_pulses;
    read_frame(4, rd_val);
    check_eq("partial_bits", {28'd0, rd_val[3:0]}, 32'hA);
    end_frame();
    check_eq("miso_abort_err", err_pulses - e0, 32'd1);
    check_eq("miso_abort_state", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});

    // Asynchronous reset after 3 of 8 MISO bits (third bit is 1).
    write_frame(2'b10, 8'h3C);
    read_frame(3, rd_val);
    check_eq("pre_reset_bits", {29'd0, rd_val[2:0]}, 32'h5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_miso", {31'd0, bus.MISO}, 32'd0);
    check_eq("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("async_rst_state", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});
    bus.SS_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_state", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});
    check_eq("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    // ---------------- final report ----------------
    check_eq("busy_in_frames", busy_low, 32'd0);
    check_eq("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_bridge_p.md
Name: spi_ram_bridge_p

Overview:
- Parametrised successor to the fixed 10-bit SPI-slave/single-port-RAM pair.
- Integrates the SPI slave FSM and the RAM in one block. Data and address widths are generic.
- Adds frame-error detection, a busy flag and optional address auto-increment (burst) mode.
- Sits at the top-level wrapper position: external SPI pins in, MISO out. The clock doubles as the SPI sample clock.

Parameters:
- DATA_WIDTH, 8, RAM word width and SPI payload width W.
- ADDR_WIDTH, 8, RAM address width A. Must satisfy A <= W. MEM_DEPTH = 2**A is a derived localparam.

Ports:
- clk  in  1  system clock and SPI sample clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_err  out  1  one-cycle pulse on an aborted or illegal frame.

Behaviour:
- Reset (async):
  - State IDLE; MISO=0, busy=0, frame_err=0.
  - wr_addr=0, rd_addr=0, rd_addr_seen=0, bit counter=0, shift register=0.
  - Memory array is not reset.
- Frame: op[1:0] followed by payload[W-1:0], MSB first, W+2 bits total. Opcodes:
  - 00: load wr_addr.
  - 01: write data.
  - 10: load rd_addr.
  - 11: read data.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, MISO_OUT.
- IDLE: SS_n sampled low -> CHK_CMD. No bit is consumed on this edge.
- CHK_CMD: samples MOSI as op[1].
  - op[1]=0 -> WRITE.
  - op[1]=1 and rd_addr_seen=0 -> READ_ADD.
  - op[1]=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift the remaining W+1 bits. On the edge that captures the last bit, an internal rx_valid pulses for one cycle carrying {op, payload}.
- Action one cycle after capture, by opcode:
  - 00: wr_addr <= payload[A-1:0].
  - 01: mem[wr_addr] <= payload.
  - 10: rd_addr <= payload[A-1:0]; rd_addr_seen <= 1.
  - 11: dout <= mem[rd_addr]; internal tx_valid next cycle; rd_addr_seen <= 0.
- State/opcode checks:
  - READ_ADD receiving op 11: frame discarded, frame_err pulses, no memory access.
  - READ_DATA receiving op 10: treated as a legal address reload, with no MISO phase.
- MISO_OUT:
  - Entered after op 11 on the cycle tx_valid is high; dout is loaded into the shift register.
  - The next W rising edges drive MISO = dout[W-1] down to dout[0].
  - MISO then returns to 0; the FSM waits for SS_n high.
  - Read latency: first MISO bit appears 2 cycles after the last MOSI bit is captured.
- After a complete frame, the FSM holds its state until SS_n goes high, then returns to IDLE. Further MOSI bits are ignored.
- SS_n high before frame completion (any non-IDLE state, bit counter < W+2, or MISO_OUT not finished):
  - frame_err pulses; FSM -> IDLE.
  - No memory or pointer update; MISO=0 on the next edge.
- SS_n high in the same cycle as the last-bit capture: the frame completes normally; no frame_err.
- Addresses wrap modulo MEM_DEPTH.
- Reset asserted mid-frame: all state is cleared immediately, asynchronously.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined:
  - After each op 01, wr_addr <= wr_addr+1 mod MEM_DEPTH.
  - After each op 11, rd_addr <= rd_addr+1 mod MEM_DEPTH, and rd_addr_seen stays 1, so consecutive read-data frames stream sequential words.
- Undefined:
  - Pointers change only on ops 00 and 10.
  - rd_addr_seen clears after op 11.

Test Plan:
- Reset: rst_n=0 for 3 cycles then release -> MISO=0, busy=0, frame_err=0; the first write-data frame after reset lands at mem[0x00].
- W=8, A=8: frames 00_0x3C, 01_0xA5, 10_0x3C, 11_0x00 -> MISO shows 1,0,1,0,0,1,0,1 starting 2 cycles after the last MOSI bit; busy high throughout each frame.
- Abort: SS_n raised after 5 bits of frame 01_0x5A to address 0x10 -> frame_err single pulse, mem[0x10] unchanged, FSM in IDLE, busy=0.
- Illegal read: after reset, send op 11 with payload 0x00 -> FSM routes to READ_ADD, frame_err pulses, MISO stays 0, rd_addr_seen stays 0.
- Auto-increment (SPI_RAM_AUTO_INC_EN): 00_0xFF, 01_0x11, 01_0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22. Then 10_0xFF, 11, 11 -> MISO returns 0x11 then 0x22. Without the macro, the second read returns via READ_ADD and raises frame_err.
- Reset mid MISO_OUT after 3 of 8 bits -> MISO=0 asynchronously, busy=0, FSM in IDLE on release.
